// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with grant hold and release.
// sel/en are registered and feed a 2-to-4 decoder whose one-hot output is the
// grant vector. At least one idle cycle separates grants (break-before-make).
// Optional watchdog: define RR_ARB_TIMEOUT_EN to revoke grants held for
// MAX_HOLD cycles; otherwise timeout is tied low and MAX_HOLD is ignored.

module rr_arbiter4 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] sel,
    output logic       en,
    output logic       timeout
);

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } state_e;

    state_e     state_q;
    logic [1:0] ptr_q;
    logic [1:0] sel_q;
    logic       en_q;

    logic [1:0] pick;
    logic       pick_valid;
    logic       release_req;
    logic       expire;

    // First requester at or after the rotating pointer, wrapping mod 4.
    always_comb begin
        pick       = ptr_q;
        pick_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!pick_valid && req[ptr_q + 2'(k)]) begin
                pick       = ptr_q + 2'(k);
                pick_valid = 1'b1;
            end
        end
    end

    // Holder releases by pulsing done or by dropping its own request.
    always_comb begin
        release_req = done | ~req[sel_q];
    end

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [7:0] HoldMax = 8'(MAX_HOLD);

    logic [7:0] hold_q;
    logic       timeout_q;

    // hold_q equals the number of cycles spent in GRANT, including the current one.
    always_comb begin
        expire = (state_q == StGrant) && (hold_q == HoldMax);
    end

    assign timeout = timeout_q;
`else
    // Parameter kept in the interface for build compatibility only.
    logic unused_max_hold;
    assign unused_max_hold = ^8'(MAX_HOLD);

    always_comb begin
        expire = 1'b0;
    end

    assign timeout = 1'b0;
`endif

    // Arbiter FSM with registered sel/en/timeout outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= 2'd0;
            sel_q     <= 2'd0;
            en_q      <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
`ifdef RR_ARB_TIMEOUT_EN
                    // Revocation pulse lasts only the first idle cycle.
                    timeout_q <= 1'b0;
`endif
                    if (pick_valid) begin
                        sel_q   <= pick;
                        en_q    <= 1'b1;
                        state_q <= StGrant;
`ifdef RR_ARB_TIMEOUT_EN
                        hold_q  <= 8'd1;
`endif
                    end
                end
                StGrant: begin
                    if (release_req || expire) begin
                        en_q      <= 1'b0;
                        ptr_q     <= sel_q + 2'd1;
                        state_q   <= StIdle;
`ifdef RR_ARB_TIMEOUT_EN
                        // A genuine release on the same edge suppresses the pulse.
                        timeout_q <= ~release_req;
                        hold_q    <= 8'd0;
`endif
                    end else begin
`ifdef RR_ARB_TIMEOUT_EN
                        hold_q    <= hold_q + 8'd1;
`endif
                    end
                end
                default: begin
                    state_q <= StIdle;
                    en_q    <= 1'b0;
                end
            endcase
        end
    end

    assign sel = sel_q;
    assign en  = en_q;

endmodule
